icache_control: RTL and testbench

Sequencing FSM for the two-way L1 instruction-cache datapath. Sits between the CPU fetch port and physical memory. Inspects the datapath's `hit`/`replace`/`dirty` status, drives its `pmem_we`, `pmarmux_sel`, `datamux_sel` and `load_addr` controls, and runs the 256-bit line write-back/fill handshake with memory. Also keeps saturating hit/miss/write-back performance counters.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/icache_control_if.sv | 40 ++++
 rtl/sat_counter.sv | 39 +++
 rtl/icache_control.sv | 143 ++++++++++++++
 tb/tb_icache_control.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 instruction-cache controller and datapath.
package cache_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        WB_ADDR,
        WRITEBACK,
        FILL_ADDR,
        FILL
    } icache_ctrl_state_t;

    // Physical-address mux: request tag (fill) or victim tag (write-back).
    localparam logic PMAR_TAG    = 1'b0;
    localparam logic PMAR_VICTIM = 1'b1;

    // Data-array input mux: memory line (fill) or merged CPU write data.
    localparam logic DMUX_PMEM   = 1'b0;
    localparam logic DMUX_CPU    = 1'b1;

endpackage

// File: rtl/icache_control_if.sv
// Bundle of CPU handshake, datapath status/control and memory handshake
// signals around the instruction-cache controller.
interface icache_control_if;

    // CPU fetch port
    logic mem_read;
    logic mem_write;
    logic mem_resp;

    // Datapath status
    logic hit;
    logic replace;
    logic dirty;

    // Datapath controls
    logic pmem_we;
    logic pmarmux_sel;
    logic datamux_sel;
    logic load_addr;

    // Physical memory line handshake
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;

    // Environment side: CPU, datapath status and memory drive the controller.
    modport master (
        output mem_read, mem_write, hit, replace, dirty, pmem_resp,
        input  mem_resp, pmem_we, pmarmux_sel, datamux_sel, load_addr,
               pmem_read, pmem_write
    );

    // Controller side.
    modport slave (
        input  mem_read, mem_write, hit, replace, dirty, pmem_resp,
        output mem_resp, pmem_we, pmarmux_sel, datamux_sel, load_addr,
               pmem_read, pmem_write
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);

    localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] count_d;
    logic [width-1:0] count_q;

    // Next count: hold unless incrementing below saturation.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/icache_control.sv
// Sequencing FSM for the two-way L1 instruction cache: hit response,
// victim write-back, line fill, and hit/miss/write-back counters.
module icache_control
    import cache_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    icache_control_if.slave  bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    icache_ctrl_state_t state_d, state_q;
    logic               miss_pending_d, miss_pending_q;

    logic mem_resp;
    logic pmem_we;
    logic pmarmux_sel;
    logic datamux_sel;
    logic load_addr;
    logic pmem_read;
    logic pmem_write;
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;
    logic req;

    assign req = bus.mem_read | bus.mem_write;

    // Next-state, miss tracking and output decode from state plus inputs.
    always_comb begin
        state_d        = state_q;
        miss_pending_d = miss_pending_q;
        mem_resp       = 1'b0;
        pmem_we        = 1'b0;
        pmarmux_sel    = PMAR_TAG;
        datamux_sel    = DMUX_PMEM;
        load_addr      = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        miss_inc       = 1'b0;
        wb_inc         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (bus.hit) begin
                        mem_resp = 1'b1;
                        // A simultaneous read+write is served as a write.
                        if (bus.mem_write) begin
                            datamux_sel = DMUX_CPU;
                        end
                    end else begin
                        miss_inc       = 1'b1;
                        miss_pending_d = 1'b1;
                        state_d        = (bus.replace && bus.dirty) ? WB_ADDR : FILL_ADDR;
                    end
                end else begin
                    // Request withdrawn mid-miss: forget it once back here.
                    miss_pending_d = 1'b0;
                end
            end
            WB_ADDR: begin
                load_addr   = 1'b1;
                pmarmux_sel = PMAR_VICTIM;
                state_d     = WRITEBACK;
            end
            WRITEBACK: begin
                pmem_write  = 1'b1;
                pmarmux_sel = PMAR_VICTIM;
                if (bus.pmem_resp) begin
                    wb_inc  = 1'b1;
                    state_d = FILL_ADDR;
                end
            end
            FILL_ADDR: begin
                load_addr   = 1'b1;
                pmarmux_sel = PMAR_TAG;
                state_d     = FILL;
            end
            FILL: begin
                pmem_read   = 1'b1;
                datamux_sel = DMUX_PMEM;
                if (bus.pmem_resp) begin
                    pmem_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mem_resp) begin
            miss_pending_d = 1'b0;
        end
        hit_inc = mem_resp && !miss_pending_q;
    end

    // State and miss-tracking registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            miss_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            miss_pending_q <= miss_pending_d;
        end
    end

    assign bus.mem_resp    = mem_resp;
    assign bus.pmem_we     = pmem_we;
    assign bus.pmarmux_sel = pmarmux_sel;
    assign bus.datamux_sel = datamux_sel;
    assign bus.load_addr   = load_addr;
    assign bus.pmem_read   = pmem_read;
    assign bus.pmem_write  = pmem_write;

    sat_counter #(.width(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.width(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

    sat_counter #(.width(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wb_inc),
        .count (wb_count)
    );

endmodule

// File: tb/tb_icache_control.sv
// Self-checking bench for icache_control: directed scenarios plus random
// transactions against a latency/counter model derived from the cache rules.
module tb_icache_control;

    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int BUDGET = 40;

    logic          clk;
    logic          rst;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;
    logic [CW-1:0] wb_count;

    icache_control_if ifc ();

    icache_control #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifc.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_hit, m_miss, m_wb;

    typedef struct {
        int resp_cyc, resp_cnt;
        int rd_first, rd_cnt;
        int wr_first, wr_cnt;
        int we_cyc, we_cnt;
        int la_cnt, la_first, la_last;
        bit la_first_pmar, la_last_pmar;
        bit pmar_bad, dmux_bad, overlap;
        bit dmux_at_resp, we_at_resp, timeout;
    } txn_t;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic drive_idle();
        ifc.mem_read  = 1'b0;
        ifc.mem_write = 1'b0;
        ifc.hit       = 1'b0;
        ifc.replace   = 1'b0;
        ifc.dirty     = 1'b0;
        ifc.pmem_resp = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
    endtask

    // One CPU request with a memory that answers after j (write) / k (read)
    // extra cycles; the line becomes present once the fill is written.
    task automatic run_txn(input bit rd, input bit wr, input bit hit0, input bit rep,
                           input bit drt, input int j, input int k, input bit spur,
                           input int drop_after, output txn_t r);
        bit present, done, req;
        int mem_cnt, cyc;
        r = '{default: 0};
        r.resp_cyc = -1; r.rd_first = -1; r.wr_first = -1; r.we_cyc = -1;
        r.la_first = -1; r.la_last = -1;
        present = hit0; done = 0; mem_cnt = 0; cyc = 0;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            req = (drop_after < 0) || (cyc < drop_after);
            ifc.mem_read  = rd & req;
            ifc.mem_write = wr & req;
            ifc.hit       = present;
            ifc.replace   = rep;
            ifc.dirty     = drt;
            ifc.pmem_resp = 1'b0;
            #1;
            if (ifc.pmem_write || ifc.pmem_read) begin
                if (mem_cnt == (ifc.pmem_write ? j : k)) ifc.pmem_resp = 1'b1;
                mem_cnt++;
            end else begin
                mem_cnt = 0;
                if (spur && $urandom_range(0, 3) == 0) ifc.pmem_resp = 1'b1;
            end
            #1;
            if (ifc.pmem_read && ifc.pmem_write) r.overlap = 1;
            if (ifc.pmem_write) begin
                if (r.wr_first < 0) r.wr_first = cyc;
                r.wr_cnt++;
                if (ifc.pmarmux_sel !== 1'b1) r.pmar_bad = 1;
            end
            if (ifc.pmem_read) begin
                if (r.rd_first < 0) r.rd_first = cyc;
                r.rd_cnt++;
                if (ifc.datamux_sel !== 1'b0) r.dmux_bad = 1;
            end
            if (ifc.load_addr) begin
                if (r.la_first < 0) begin
                    r.la_first      = cyc;
                    r.la_first_pmar = ifc.pmarmux_sel;
                end
                r.la_last      = cyc;
                r.la_last_pmar = ifc.pmarmux_sel;
                r.la_cnt++;
            end
            if (ifc.pmem_we) begin
                r.we_cnt++;
                r.we_cyc = cyc;
                present  = 1;
                if (drop_after >= 0) done = 1;
            end
            if (ifc.mem_resp) begin
                r.resp_cnt++;
                r.resp_cyc     = cyc;
                r.dmux_at_resp = ifc.datamux_sel;
                r.we_at_resp   = ifc.pmem_we;
                done = 1;
            end
            cyc++;
        end
        r.timeout = !done;
        @(negedge clk);
        drive_idle();
        #2;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        #2;
        total++;
        if ({ifc.mem_resp, ifc.pmem_we, ifc.pmarmux_sel, ifc.datamux_sel, ifc.load_addr,
             ifc.pmem_read, ifc.pmem_write} !== 7'b0) begin
            bad++; $display("FAIL reset outputs: got nonzero, want all 0");
        end
        total++;
        if ({hit_count, miss_count, wb_count} !== '0) begin
            bad++; $display("FAIL reset counters: got h=%0d m=%0d w=%0d want 0", hit_count, miss_count, wb_count);
        end
    endtask

    task automatic test_read_hit();
        txn_t r;
        apply_reset();
        run_txn(1, 0, 1, 0, 0, 0, 0, 0, -1, r);
        m_hit = sat_inc(m_hit);
        total++;
        if (r.resp_cyc !== 0) begin bad++; $display("FAIL read_hit resp_cyc: got %0d want 0", r.resp_cyc); end
        total++;
        if (r.rd_cnt + r.wr_cnt + r.we_cnt + r.la_cnt !== 0) begin
            bad++; $display("FAIL read_hit pmem_activity: got %0d want 0", r.rd_cnt + r.wr_cnt + r.we_cnt + r.la_cnt);
        end
        total++;
        if (r.dmux_at_resp !== 1'b0) begin bad++; $display("FAIL read_hit datamux_sel: got 1 want 0"); end
        total++;
        if ({hit_count, miss_count, wb_count} !== {CW'(m_hit), CW'(m_miss), CW'(m_wb)}) begin
            bad++; $display("FAIL read_hit counters: got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                            hit_count, miss_count, wb_count, m_hit, m_miss, m_wb);
        end
    endtask

    task automatic test_clean_miss();
        txn_t r;
        apply_reset();
        run_txn(1, 0, 0, 0, 0, 0, 3, 0, -1, r);
        m_miss = sat_inc(m_miss);
        total++;
        if (r.la_cnt !== 1 || r.la_first !== 1 || r.la_first_pmar !== 1'b0) begin
            bad++; $display("FAIL clean_miss load_addr: got cnt=%0d at %0d pmar=%0d want cnt=1 at 1 pmar=0",
                            r.la_cnt, r.la_first, r.la_first_pmar);
        end
        total++;
        if (r.rd_first !== 2 || r.rd_cnt !== 4) begin
            bad++; $display("FAIL clean_miss pmem_read: got first=%0d cnt=%0d want first=2 cnt=4", r.rd_first, r.rd_cnt);
        end
        total++;
        if (r.we_cyc !== 5 || r.we_cnt !== 1 || r.wr_cnt !== 0) begin
            bad++; $display("FAIL clean_miss pmem_we: got at %0d cnt=%0d wr=%0d want at 5 cnt=1 wr=0", r.we_cyc, r.we_cnt, r.wr_cnt);
        end
        total++;
        if (r.resp_cyc !== 6) begin bad++; $display("FAIL clean_miss resp_cyc: got %0d want 6", r.resp_cyc); end
        total++;
        if ({hit_count, miss_count, wb_count} !== {CW'(m_hit), CW'(m_miss), CW'(m_wb)}) begin
            bad++; $display("FAIL clean_miss counters: got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                            hit_count, miss_count, wb_count, m_hit, m_miss, m_wb);
        end
    endtask

    task automatic test_dirty_miss();
        txn_t r;
        apply_reset();
        run_txn(1, 0, 0, 1, 1, 2, 2, 0, -1, r);
        m_miss = sat_inc(m_miss);
        m_wb   = sat_inc(m_wb);
        total++;
        if (r.wr_first !== 2 || r.wr_cnt !== 3 || r.pmar_bad !== 1'b0) begin
            bad++; $display("FAIL dirty_miss pmem_write: got first=%0d cnt=%0d pmar_bad=%0d want first=2 cnt=3 pmar_bad=0",
                            r.wr_first, r.wr_cnt, r.pmar_bad);
        end
        total++;
        if (r.la_cnt !== 2 || r.la_first !== 1 || r.la_first_pmar !== 1'b1 ||
            r.la_last !== 5 || r.la_last_pmar !== 1'b0) begin
            bad++; $display("FAIL dirty_miss load_addr: got cnt=%0d %0d/%0d %0d/%0d want cnt=2 1/1 5/0",
                            r.la_cnt, r.la_first, r.la_first_pmar, r.la_last, r.la_last_pmar);
        end
        total++;
        if (r.rd_first !== 6 || r.rd_cnt !== 3 || r.we_cyc !== 8 || r.overlap !== 1'b0) begin
            bad++; $display("FAIL dirty_miss fill: got rd_first=%0d rd_cnt=%0d we=%0d ovl=%0d want 6 3 8 0",
                            r.rd_first, r.rd_cnt, r.we_cyc, r.overlap);
        end
        total++;
        if (r.resp_cyc !== 9) begin bad++; $display("FAIL dirty_miss resp_cyc: got %0d want 9", r.resp_cyc); end
        total++;
        if ({hit_count, miss_count, wb_count} !== {CW'(m_hit), CW'(m_miss), CW'(m_wb)}) begin
            bad++; $display("FAIL dirty_miss counters: got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                            hit_count, miss_count, wb_count, m_hit, m_miss, m_wb);
        end
    endtask

    // Read and write both high is served as a write.
    task automatic test_write_hit();
        txn_t r;
        apply_reset();
        run_txn(1, 1, 1, 1, 1, 0, 0, 0, -1, r);
        m_hit = sat_inc(m_hit);
        total++;
        if (r.resp_cyc !== 0 || r.dmux_at_resp !== 1'b1 || r.we_at_resp !== 1'b0) begin
            bad++; $display("FAIL write_hit resp: got cyc=%0d dmux=%0d we=%0d want cyc=0 dmux=1 we=0",
                            r.resp_cyc, r.dmux_at_resp, r.we_at_resp);
        end
        total++;
        if ({hit_count, miss_count, wb_count} !== {CW'(m_hit), CW'(m_miss), CW'(m_wb)}) begin
            bad++; $display("FAIL write_hit counters: got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                            hit_count, miss_count, wb_count, m_hit, m_miss, m_wb);
        end
    endtask

    task automatic test_reset_in_fill();
        bit seen;
        apply_reset();
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            drive_idle();
            ifc.mem_read = 1'b1;
            #2;
            if (ifc.pmem_read) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rst_in_fill reach_fill: got no pmem_read want pmem_read"); end
        total++;
        if (miss_count !== CW'(1)) begin bad++; $display("FAIL rst_in_fill pre_miss: got %0d want 1", miss_count); end
        rst = 1'b1;
        ifc.mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        #2;
        total++;
        if ({ifc.mem_resp, ifc.pmem_we, ifc.load_addr, ifc.pmem_read, ifc.pmem_write} !== 5'b0) begin
            bad++; $display("FAIL rst_in_fill outputs: got pmem_read=%0d want all 0", ifc.pmem_read);
        end
        total++;
        if ({hit_count, miss_count, wb_count} !== '0) begin
            bad++; $display("FAIL rst_in_fill counters: got h=%0d m=%0d w=%0d want 0", hit_count, miss_count, wb_count);
        end
    endtask

    // Request withdrawn mid-miss: fill still completes, no response, and the
    // next hit counts as a hit again.
    task automatic test_dropped();
        txn_t r;
        apply_reset();
        run_txn(1, 0, 0, 1, 1, 1, 1, 0, 2, r);
        m_miss = sat_inc(m_miss);
        m_wb   = sat_inc(m_wb);
        total++;
        if (r.timeout || r.resp_cnt !== 0 || r.we_cnt !== 1 || r.wr_cnt !== 2 || r.rd_cnt !== 2) begin
            bad++; $display("FAIL dropped flow: got to=%0d resp=%0d we=%0d wr=%0d rd=%0d want 0 0 1 2 2",
                            r.timeout, r.resp_cnt, r.we_cnt, r.wr_cnt, r.rd_cnt);
        end
        run_txn(1, 0, 1, 0, 0, 0, 0, 0, -1, r);
        m_hit = sat_inc(m_hit);
        total++;
        if ({hit_count, miss_count, wb_count} !== {CW'(m_hit), CW'(m_miss), CW'(m_wb)}) begin
            bad++; $display("FAIL dropped counters: got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                            hit_count, miss_count, wb_count, m_hit, m_miss, m_wb);
        end
    endtask

    task automatic test_saturation();
        txn_t r;
        apply_reset();
        for (int i = 0; i < CMAX; i++) begin
            run_txn(1, 0, 0, 0, 0, 0, $urandom_range(0, 2), 0, -1, r);
        end
        total++;
        if (miss_count !== CW'(CMAX)) begin bad++; $display("FAIL sat preload: got %0d want %0d", miss_count, CMAX); end
        run_txn(1, 0, 0, 0, 0, 0, 1, 0, -1, r);
        total++;
        if (miss_count !== CW'(CMAX) || hit_count !== '0) begin
            bad++; $display("FAIL sat hold: got m=%0d h=%0d want m=%0d h=0", miss_count, hit_count, CMAX);
        end
    endtask

    task automatic test_random();
        txn_t r;
        bit rd, wr, hit0, rep, drt, evict;
        int j, k, exp_resp, exp_rd_first;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            wr    = $urandom_range(0, 1);
            rd    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            hit0  = $urandom_range(0, 1);
            rep   = $urandom_range(0, 1);
            drt   = $urandom_range(0, 1);
            j     = $urandom_range(0, 3);
            k     = $urandom_range(0, 3);
            evict = rep & drt;
            run_txn(rd, wr, hit0, rep, drt, j, k, 1, -1, r);
            if (hit0) begin
                m_hit = sat_inc(m_hit);
            end else begin
                m_miss = sat_inc(m_miss);
                if (evict) m_wb = sat_inc(m_wb);
            end
            exp_resp     = hit0 ? 0 : (evict ? 5 + j + k : 3 + k);
            exp_rd_first = hit0 ? -1 : (evict ? 4 + j : 2);
            total++;
            if (r.resp_cyc !== exp_resp) begin
                bad++; $display("FAIL rand[%0d] resp_cyc: got %0d want %0d", n, r.resp_cyc, exp_resp);
            end
            total++;
            if (r.rd_first !== exp_rd_first || r.rd_cnt !== (hit0 ? 0 : k + 1) ||
                r.wr_cnt !== ((!hit0 && evict) ? j + 1 : 0)) begin
                bad++; $display("FAIL rand[%0d] pmem: got rd@%0d x%0d wr x%0d want rd@%0d x%0d wr x%0d", n,
                                r.rd_first, r.rd_cnt, r.wr_cnt, exp_rd_first,
                                hit0 ? 0 : k + 1, (!hit0 && evict) ? j + 1 : 0);
            end
            total++;
            if (r.la_last !== (hit0 ? -1 : exp_rd_first - 1) || r.we_cnt !== (hit0 ? 0 : 1)) begin
                bad++; $display("FAIL rand[%0d] load/we: got la@%0d we x%0d want la@%0d we x%0d", n,
                                r.la_last, r.we_cnt, hit0 ? -1 : exp_rd_first - 1, hit0 ? 0 : 1);
            end
            total++;
            if (r.overlap || r.pmar_bad || r.dmux_bad || r.dmux_at_resp !== wr) begin
                bad++; $display("FAIL rand[%0d] muxes: got ovl=%0d pmar=%0d dmux=%0d resp_dmux=%0d want 0 0 0 %0d",
                                n, r.overlap, r.pmar_bad, r.dmux_bad, r.dmux_at_resp, wr);
            end
            total++;
            if ({hit_count, miss_count, wb_count} !== {CW'(m_hit), CW'(m_miss), CW'(m_wb)}) begin
                bad++; $display("FAIL rand[%0d] counters: got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                                n, hit_count, miss_count, wb_count, m_hit, m_miss, m_wb);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_miss();
        test_write_hit();
        test_reset_in_fill();
        test_dropped();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
